// File: rtl/os_pkg.sv
// Shared types and helpers for the output-stationary PE row and its readout stages.
package os_pkg;

  localparam int OP_SIZE_DEFAULT = 48;
  localparam int SAT_W           = 128;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_kind_t;

  // Classifies a sign-extended value against the signed range of 'width' bits.
  function automatic sat_kind_t sat_signed(input logic signed [SAT_W-1:0] value,
                                           input int width);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    hi  = (one <<< (width - 1)) - one;
    lo  = -(one <<< (width - 1));
    if (value > hi)      return SAT_HI;
    else if (value < lo) return SAT_LO;
    else                 return SAT_NONE;
  endfunction

endpackage

// File: rtl/os_row_drain_if.sv
// Streaming result port of a drain stage: valid/ready plus index, last and saturation sidebands.
interface os_row_drain_if #(
    parameter int N        = 8,
    parameter int OUT_size = 16
);
    localparam int IDX_W = $clog2(N);

    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUT_size-1:0] out_data;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_last;
    logic                       out_sat;

    modport master (
        output out_valid, out_data, out_idx, out_last, out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last, out_sat,
        output out_ready
    );
endinterface

// File: rtl/os_quantizer.sv
// Round-half-up arithmetic shift followed by signed saturation to OUT_size bits.
module os_quantizer
    import os_pkg::*;
#(
    parameter int OP_size  = OP_SIZE_DEFAULT,
    parameter int OUT_size = 16,
    parameter int SHIFT    = 8
) (
    input  logic signed [OP_size-1:0]  acc,
    output logic signed [OUT_size-1:0] data,
    output logic                       sat
);
    // One guard bit so the rounding add cannot wrap at the positive extreme.
    localparam int W = OP_size + 1;
    localparam logic signed [W-1:0] HALF = W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0);

    logic signed [W-1:0] ext;
    logic signed [W-1:0] t;
    sat_kind_t           kind;

    assign ext = {acc[OP_size-1], acc};

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
        t    = ext;
        data = '0;
        if (SHIFT > 0) t = (ext + HALF) >>> SHIFT;
        kind = sat_signed({{(SAT_W - W){t[W-1]}}, t}, OUT_size);
        unique case (kind)
            SAT_HI:  data = {1'b0, {(OUT_size - 1){1'b1}}};
            SAT_LO:  data = {1'b1, {(OUT_size - 1){1'b0}}};
            default: data = t[OUT_size-1:0];
        endcase
        sat = (kind != SAT_NONE);
    end
endmodule

// File: rtl/os_row_drain.sv
// Snapshots a row of N PE accumulators on capture and streams them out quantized, one per handshake.
module os_row_drain
    import os_pkg::*;
#(
    parameter int N        = 8,
    parameter int OP_size  = OP_SIZE_DEFAULT,
    parameter int OUT_size = 16,
    parameter int SHIFT    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic [N*OP_size-1:0]   acc_in,
    os_row_drain_if.master         strm,
    output logic                   busy,
    output logic                   capture_drop
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t               state, state_d;
    logic [IDX_W-1:0]           idx, idx_d;
    logic signed [OP_size-1:0]  shadow [N];
    logic                       load;
    logic                       drop_set;
    logic                       hs;
    logic                       at_last;

    assign hs      = (state == STREAM) && strm.out_ready;
    assign at_last = (idx == LAST_IDX);

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        load     = 1'b0;
        drop_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs && at_last) begin
                    idx_d = '0;
                    // A capture on the final handshake refills the shadow with no bubble.
                    if (capture) load = 1'b1;
                    else         state_d = IDLE;
                end else begin
                    if (hs) idx_d = idx + 1'b1;
                    if (capture) drop_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            capture_drop <= 1'b0;
            // NOTE: the shadow bank is reset on purpose so the muxed output path reads zero out of reset.
            for (int i = 0; i < N; i++) shadow[i] <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (drop_set) capture_drop <= 1'b1;
            if (load) begin
                for (int i = 0; i < N; i++) shadow[i] <= acc_in[i*OP_size +: OP_size];
            end
        end
    end

    os_quantizer #(
        .OP_size (OP_size),
        .OUT_size(OUT_size),
        .SHIFT   (SHIFT)
    ) u_quant (
        .acc (shadow[idx]),
        .data(strm.out_data),
        .sat (strm.out_sat)
    );

    assign strm.out_valid = (state == STREAM);
    assign strm.out_idx   = idx;
    assign strm.out_last  = (state == STREAM) && at_last;
    assign busy           = (state == STREAM);
endmodule

// File: tb/tb_os_row_drain.sv
// Scoreboard bench for os_row_drain: directed scenarios followed by random capture/ready traffic.
module tb_os_row_drain;
    localparam int N      = 4;
    localparam int OP_W   = 48;
    localparam int OUT_W  = 8;
    localparam int SHIFT  = 4;

    typedef struct {
        longint data;
        bit     sat;
        int     idx;
        bit     last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              capture;
    logic [N*OP_W-1:0] acc_in;
    logic              busy;
    logic              capture_drop;

    os_row_drain_if #(.N(N), .OUT_size(OUT_W)) strm ();

    os_row_drain #(
        .N(N), .OP_size(OP_W), .OUT_size(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .acc_in      (acc_in),
        .strm        (strm.master),
        .busy        (busy),
        .capture_drop(capture_drop)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint acc_v [N];
    exp_t   exp_q [$];
    int     remaining = 0;
    bit     drop_exp  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Reference quantizer: floor((acc + 2^(S-1)) / 2^S), then clamp to the OUT_W signed range.
    function automatic exp_t quant(input longint acc, input int i);
        exp_t   e;
        longint t;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(hi + 1);
        t  = (SHIFT > 0) ? ((acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT) : acc;
        e.sat = 1'b1;
        if (t > hi)      e.data = hi;
        else if (t < lo) e.data = lo;
        else begin
            e.data = t;
            e.sat  = 1'b0;
        end
        e.idx  = i;
        e.last = (i == N - 1);
        return e;
    endfunction

    // Model: a stream is a list of N pending results; a capture is taken only when nothing is left pending.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            remaining = 0;
            drop_exp  = 0;
        end else begin
            if (remaining > 0 && strm.out_ready) remaining--;
            if (capture) begin
                if (remaining == 0) begin
                    for (int i = 0; i < N; i++) exp_q.push_back(quant(acc_v[i], i));
                    remaining = N;
                end else begin
                    drop_exp = 1;
                end
            end
        end
    end

    bit                    prev_stall = 0;
    logic signed [OUT_W-1:0] hold_data;
    logic [1:0]            hold_idx;
    logic                  hold_last, hold_sat;

    always @(negedge clk) begin
        exp_t e;
        check("out_valid", {63'd0, strm.out_valid}, {63'd0, remaining > 0});
        check("busy", {63'd0, busy}, {63'd0, remaining > 0});
        check("capture_drop", {63'd0, capture_drop}, {63'd0, drop_exp});
        if (!strm.out_valid) check("out_last_idle", {63'd0, strm.out_last}, 64'd0);
        if (prev_stall && strm.out_valid) begin
            check("hold_data", 64'(strm.out_data), 64'(hold_data));
            check("hold_idx", 64'(strm.out_idx), 64'(hold_idx));
            check("hold_last", {63'd0, strm.out_last}, {63'd0, hold_last});
            check("hold_sat", {63'd0, strm.out_sat}, {63'd0, hold_sat});
        end
        if (strm.out_valid && strm.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_element: idx %0d data %0d with nothing expected",
                         strm.out_idx, strm.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(strm.out_data), 64'(e.data));
                check("out_sat", {63'd0, strm.out_sat}, {63'd0, e.sat});
                check("out_idx", 64'(strm.out_idx), 64'(e.idx));
                check("out_last", {63'd0, strm.out_last}, {63'd0, e.last});
            end
        end
        prev_stall = strm.out_valid && !strm.out_ready;
        hold_data  = strm.out_data;
        hold_idx   = strm.out_idx;
        hold_last  = strm.out_last;
        hold_sat   = strm.out_sat;
    end

    task automatic set_acc(input longint a0, input longint a1, input longint a2, input longint a3);
        acc_v[0] = a0;
        acc_v[1] = a1;
        acc_v[2] = a2;
        acc_v[3] = a3;
        for (int i = 0; i < N; i++) acc_in[i*OP_W +: OP_W] = acc_v[i][OP_W-1:0];
    endtask

    task automatic step(input bit cap, input bit rdy);
        capture        = cap;
        strm.out_ready = rdy;
        @(posedge clk);
        #1;
        capture = 1'b0;
    endtask

    task automatic run_to(input int rem);
        for (int k = 0; k < 20 && remaining != rem; k++) step(1'b0, 1'b1);
        check("reach_remaining", 64'(remaining), 64'(rem));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        bit [1:0] ready_pat [7];
        ready_pat = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
        capture        = 1'b0;
        strm.out_ready = 1'b0;
        set_acc(0, 0, 0, 0);
        do_reset();

        @(negedge clk);
        check("rst_out_data", 64'(strm.out_data), 64'd0);
        check("rst_out_idx", 64'(strm.out_idx), 64'd0);
        check("rst_out_sat", {63'd0, strm.out_sat}, 64'd0);
        check("rst_out_last", {63'd0, strm.out_last}, 64'd0);

        // Basic stream
        set_acc(40, -40, 7, 0);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        // Saturation
        set_acc(5000, -5000, 2039, 2040);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        // Backpressure
        set_acc(16, 32, 48, 64);
        step(1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, ready_pat[k][0]);
        step(1'b0, 1'b1);

        // Back-to-back capture on the final handshake
        set_acc(16, 32, 48, 64);
        step(1'b1, 1'b1);
        run_to(1);
        set_acc(144, 144, 144, 144);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        // Dropped capture mid-stream
        set_acc(100, 200, 300, 400);
        step(1'b1, 1'b1);
        run_to(3);
        set_acc(-7000, 7000, 1, 2);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        // Reset mid-stream
        set_acc(50, 60, 70, 80);
        step(1'b1, 1'b1);
        run_to(2);
        rst = 1'b0;
        step(1'b0, 1'b1);
        @(negedge clk);
        check("midrst_out_idx", 64'(strm.out_idx), 64'd0);
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 3) begin
                longint a [N];
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        a[i] = longint'(int'($urandom_range(0, 8000)) - 4000);
                    end else begin
                        a[i] = {$urandom, $urandom};
                        a[i] = (a[i] <<< (64 - OP_W)) >>> (64 - OP_W);
                    end
                end
                set_acc(a[0], a[1], a[2], a[3]);
            end
            rst = ($urandom_range(0, 149) != 0);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
            rst = 1'b1;
        end
        repeat (8) step(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/os_row_drain.md
Name: os_row_drain

Overview:
- Output-stationary readout stage sitting directly downstream of a row of N output-stationary MAC PEs.
- On a capture pulse it snapshots all N accumulators in parallel into shadow registers, freeing the PEs to start the next tile.
- It then streams the N results one per handshake over a valid/ready port, each rounded and saturated to the output width, with index, last and saturation sidebands.

Parameters:
- N, 8, number of PEs (accumulators) per row; must be >= 2.
- OP_size, 48, signed accumulator width of each PE result.
- OUT_size, 16, signed width of each streamed result; must be <= OP_size.
- SHIFT, 8, arithmetic right-shift applied before saturation; range 0..OP_size-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
- capture  in  1  one-cycle pulse: snapshot acc_in now.
- acc_in  in  N*OP_size  packed accumulators; element i occupies bits [i*OP_size +: OP_size].
- out_valid  out  1  streamed element valid.
- out_ready  in  1  consumer accept.
- out_data  out  OUT_size  quantized element (signed).
- out_idx  out  $clog2(N)  index of the current element.
- out_last  out  1  high while out_idx == N-1 and out_valid.
- out_sat  out  1  high if the current element saturated.
- busy  out  1  high in STREAM.
- capture_drop  out  1  sticky flag: a capture was ignored while busy.

Behaviour:
- Reset (rst == 0 at a clk edge): state IDLE; idx = 0; shadow registers cleared to 0; capture_drop = 0. As a result out_valid, out_last, busy, out_sat, out_data and out_idx all read 0.
- FSM has two states:
  - IDLE: out_valid = 0. capture = 1 latches every acc_in element into shadow, sets idx = 0, and moves to STREAM. out_valid is 1 in the cycle after the capture edge (latency 1).
  - STREAM: out_valid = 1. A handshake is out_valid & out_ready at an edge.
    - Handshake with idx < N-1: idx increments.
    - Handshake with idx == N-1: return to IDLE and set idx = 0.
    - No handshake: nothing changes.
- AXI-style hold rule: while out_valid & !out_ready, out_data, out_idx, out_last and out_sat remain stable.
- Sideband sourcing: out_data and out_sat are combinational from shadow[idx] through the quantizer. All inputs to that path are registers; there is no combinational path from acc_in or out_ready to any output.
- Quantization, computed in OP_size+1 bits:
  - If SHIFT > 0: t = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up).
  - If SHIFT == 0: t = acc.
  - If t > 2^(OUT_size-1)-1, output the max value and set out_sat = 1.
  - If t < -2^(OUT_size-1), output the min value and set out_sat = 1.
  - Otherwise output the low OUT_size bits of t and set out_sat = 0.
  - The +1 guard bit prevents wrap in the rounding add at the positive extreme.
- Simultaneous events:
  - capture in the same cycle as the final handshake (idx == N-1): accepted back-to-back. State stays STREAM, idx = 0, shadow reloads, and out_valid never drops.
  - capture in STREAM at any other time: ignored; shadow is unchanged and capture_drop is set (sticky until reset).
  - capture in IDLE with out_ready high: no effect beyond a normal capture.
- Reset mid-stream: the in-flight stream is abandoned. The next cycle shows out_valid = 0, and no partial element is replayed.
- Upstream timing: the controller issues capture only after the final valid accumulate of the tile has landed in the PEs. The PE mac_out is stable from then until the next tile's first clear-load, so a single-cycle snapshot is sufficient.

Decomposition:
- Package os_pkg holds:
  - the default OP_size (48) shared with the PE;
  - typedef drain_state_t enum {IDLE, STREAM};
  - function sat_signed(value, width) for the saturation range checks.
- Sub-module os_quantizer (parameters OP_size, OUT_size, SHIFT; combinational acc -> data, sat) is instantiated once on the muxed path. It is reused by column drains later.

Test Plan:
- Basic stream (N=4, OUT_size=8, SHIFT=4): capture with acc_in = {40, -40, 7, 0}, out_ready held 1.
  - Required: out_data = 3, -2, 0, 0 on 4 consecutive cycles starting 1 cycle after capture.
  - out_idx = 0..3; out_last only on idx 3; busy low on the next cycle.
- Saturation (same config): acc_in = {5000, -5000, 2039, 2040}.
  - Required: out_data = 127/sat = 1, -128/sat = 1, 127/sat = 0, 127/sat = 1.
- Backpressure: out_ready pattern 0,0,1,0,1,1,1 with acc_in = {1,2,3,4}·16.
  - Required: out_data holds 1 across stalls; elements appear exactly once in order 1,2,3,4.
- Back-to-back: second capture (acc_in = {9,9,9,9}·16) on the idx 3 handshake cycle.
  - Required: out_valid stays 1; the next element is idx 0 with data 9; capture_drop stays 0.
- Drop: capture on idx 1 mid-stream.
  - Required: the stream continues with the old values; capture_drop = 1 from the next cycle until reset.
- Reset mid-stream: drive rst = 0 at idx 2.
  - Required: next cycle out_valid = 0, busy = 0, capture_drop = 0, out_idx = 0.
